// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one 32-bit single-port RAM bus between the fetch port (read-only) and the data port (loads/stores).
// Latency: request seen in IDLE at cycle 0, strobe at cycle 1, ack at cycle k, result held and stall released at cycle k+1.
// Backpressure: per-port stall requests stay high until that port's access is done; results hold while stall_i is high.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        i_ce_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_stallreq_o,
  input  logic        d_ce_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_stallreq_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  output logic        bus_we_o,
  output logic        bus_stb_o,
  output logic        bus_cyc_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } state_t;

  // Last counter value before an unacknowledged access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        i_done;
  logic        d_done;
  logic        discard;
  logic [7:0]  cnt;
  logic        acc_exit;
  logic [31:0] acc_word;

  // A port stalls the pipeline whenever it asks for an access that has not finished yet.
  assign i_stallreq_o = i_ce_i & ~i_done;
  assign d_stallreq_o = d_ce_i & ~d_done;

  // The bus cycle ends on ack, or when the wait budget is used up.
  assign acc_exit = bus_ack_i || (cnt == CNT_LAST);
  // Only an acknowledged load returns data; stores and aborted accesses deliver zero.
  assign acc_word = (bus_ack_i && !bus_we_o) ? bus_rdata_i : 32'h0;

  // Arbitration FSM with registered bus outputs, held results and done/discard bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus_addr_o    <= 32'h0;
      bus_wdata_o   <= 32'h0;
      bus_sel_o     <= 4'h0;
      bus_we_o      <= 1'b0;
      bus_stb_o     <= 1'b0;
      bus_cyc_o     <= 1'b0;
      bus_timeout_o <= 1'b0;
      i_rdata_o     <= 32'h0;
      d_rdata_o     <= 32'h0;
      i_done        <= 1'b0;
      d_done        <= 1'b0;
      discard       <= 1'b0;
      cnt           <= 8'h0;
    end else begin
      bus_timeout_o <= 1'b0;
      // The pipeline consumes held results on any unstalled cycle; a flush throws them away.
      if (!stall_i || flush_i) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (d_ce_i && !d_done) begin
            bus_addr_o  <= d_addr_i;
            bus_wdata_o <= d_wdata_i;
            bus_sel_o   <= d_sel_i;
            bus_we_o    <= d_we_i;
            bus_stb_o   <= 1'b1;
            bus_cyc_o   <= 1'b1;
            state       <= D_ACC;
          end else if (i_ce_i && !i_done) begin
            bus_addr_o  <= i_addr_i;
            bus_wdata_o <= 32'h0;
            bus_sel_o   <= 4'b1111;
            bus_we_o    <= 1'b0;
            bus_stb_o   <= 1'b1;
            bus_cyc_o   <= 1'b1;
            state       <= I_ACC;
          end
        end
        D_ACC, I_ACC: begin
          if (acc_exit) begin
            bus_stb_o     <= 1'b0;
            bus_cyc_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_timeout_o <= !bus_ack_i;
            cnt           <= 8'h0;
            discard       <= 1'b0;
            state         <= IDLE;
            // A flushed access still finishes on the bus, but its result never reaches the pipeline.
            if (!discard && !flush_i) begin
              if (state == D_ACC) begin
                d_done    <= 1'b1;
                d_rdata_o <= acc_word;
              end else begin
                i_done    <= 1'b1;
                i_rdata_o <= acc_word;
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (flush_i) begin
              discard <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
